coef_bank: RTL
==============

Name: coef_bank

Overview:
Coefficient store that answers the lowpass filter's coefficient fetch port. The filter drives `coefaddress`; this block returns `coefdata` one cycle later.
- Holds two banks of tap coefficients: one active, one shadow.
- A host streams a new coefficient set into the shadow bank through a valid/ready port.
- The banks swap only on a filter frame boundary, so no output sample ever mixes two coefficient sets.

Parameters:
DATA_W, 18, coefficient width (matches filter coefdata)
ADDR_W, 7, coefficient address width (matches filter coefaddress)
NTAPS, 65, number of taps per bank; valid addresses 0..NTAPS-1

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
coefaddress  in  ADDR_W  tap index from filter
coefdata  out  DATA_W  registered coefficient for address sampled on previous edge
coef_valid  out  1  high when active bank holds a complete loaded set
load_start  in  1  pulse: begin (or restart) loading shadow bank at index 0
wr_valid  in  1  host write strobe
wr_data  in  DATA_W  coefficient word, written in ascending tap order
wr_ready  out  1  block accepts wr_data this cycle
frame_sync  in  1  pulse from filter at end of each output computation (safe swap point)
load_full  out  1  shadow bank complete, swap pending
swap_done  out  1  one-cycle pulse on the cycle after a swap
active_bank  out  1  index of bank currently served to filter

Behaviour:
- Reset values:
  - coefdata=0, coef_valid=0, wr_ready=0, load_full=0, swap_done=0, active_bank=0.
  - FSM=IDLE, write pointer=0, bank_valid[1:0]=0.
  - RAM contents are not reset.
- Read path, 1-cycle latency:
  - At each edge, coefdata <= RAM[{active_bank, coefaddress}], using active_bank as it was before that edge.
  - If coefaddress >= NTAPS, or bank_valid[active_bank]=0, coefdata <= 0.
  - Reads never stall.
- FSM states: IDLE, LOAD, FULL.
- IDLE:
  - wr_ready=0.
  - load_start -> LOAD, ptr=0.
- LOAD:
  - wr_ready=1.
  - wr_valid&&wr_ready writes RAM[{~active_bank, ptr}] <= wr_data, then ptr++.
  - On the accepted write with ptr==NTAPS-1: go to FULL, set bank_valid[~active_bank]=1, load_full=1.
  - load_start in LOAD: ptr=0 and stay in LOAD. A wr_valid in the same cycle is ignored; load_start has priority.
  - wr_valid while wr_ready=0 is dropped silently.
- FULL:
  - wr_ready=0, load_full=1.
  - frame_sync: active_bank toggles, swap_done pulses next cycle, load_full=0, then -> IDLE.
  - load_start without frame_sync: discard pending set, clear bank_valid[~active_bank], ptr=0 -> LOAD.
  - load_start together with frame_sync: the swap happens first, then -> LOAD with ptr=0, targeting the new shadow (the old active bank).
- frame_sync in IDLE or LOAD: no effect.
- Shadow bank_valid is cleared when loading into it starts, so a half-loaded bank is never marked valid.
- coef_valid = bank_valid[active_bank], registered with the same timing as coefdata.
- Reset mid-load: loading is abandoned and both banks are invalidated. After reset the filter reads 0 until a full load and swap have completed.
- Widths: ptr is ADDR_W bits and never exceeds NTAPS-1. RAM depth is 2^(ADDR_W+1) words of DATA_W.

Decomposition:
- Shared package `coef_pkg`: DATA_W, ADDR_W, NTAPS localparams; FSM state encoding IDLE/LOAD/FULL.
- One sub-module: `coef_ram_2p`, a simple dual-port synchronous RAM.
  - Write port: address {~active_bank, ptr}.
  - Read port: address {active_bank, coefaddress}, registered output.
- The out-of-range and invalid-bank zeroing is applied after the RAM output register.
  - Its qualifier is pipelined by one cycle to match the RAM read latency.

Test Plan:
1. Reset, then coefaddress=0..64 -> coefdata=0 and coef_valid=0 for every address; wr_ready=0.
2. load_start, then 65 words 100..164 with wr_valid held high -> wr_ready low after the 65th word, load_full=1. Reads still return 0 because the active bank is invalid.
3. After test 2, pulse frame_sync -> swap_done pulses 1 cycle later, active_bank=1, coef_valid=1. Reading address 10 returns 110 one cycle later; address 70 returns 0.
4. Load 200..264 into the shadow bank. Issue frame_sync in the same cycle as a read of address 5:
   - That read returns 105 (old bank).
   - The next read of address 5 returns 205.
5. Write 30 words, pulse load_start, then write 65 words 300..364 and swap -> addresses 0..64 read 300..364, with no stale words from the aborted load.
6. In FULL, assert load_start and frame_sync together -> swap occurs, state=LOAD, wr_ready=1, ptr=0. Then assert reset mid-load -> all outputs return to reset values and subsequent reads return 0.

Source files
------------

// File: rtl/coef_pkg.sv
// Shared widths and load-FSM encoding for the double-buffered coefficient store.
package coef_pkg;
  localparam int DATA_W = 18;
  localparam int ADDR_W = 7;
  localparam int NTAPS  = 65;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } load_state_t;
endpackage

// File: rtl/coef_ram_2p.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module coef_ram_2p #(
  parameter int DW = 18,
  parameter int AW = 8
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/coef_bank.sv
// Two-bank coefficient store: filter reads the active bank while the host fills
// the shadow bank; banks swap only on a filter frame boundary.
//
// state | meaning
// IDLE  | no load in progress, shadow bank idle
// LOAD  | accepting host words into shadow bank at ptr
// FULL  | shadow bank complete, waiting for frame_sync to swap
module coef_bank
  import coef_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] coefaddress,
  output logic [DATA_W-1:0] coefdata,
  output logic              coef_valid,
  input  logic              load_start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              frame_sync,
  output logic              load_full,
  output logic              swap_done,
  output logic              active_bank
);
  load_state_t       state;
  logic [ADDR_W-1:0] ptr;
  logic [1:0]        bank_valid;
  logic              shadow;
  logic              wr_en;
  logic              rd_ok;
  logic [DATA_W-1:0] ram_q;

  assign shadow = ~active_bank;
  // load_start wins over a same-cycle write strobe
  assign wr_en  = (state == LOAD) && wr_valid && !load_start;

  coef_ram_2p #(.DW(DATA_W), .AW(ADDR_W + 1)) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr ({shadow, ptr}),
    .wr_data (wr_data),
    .rd_addr ({active_bank, coefaddress}),
    .rd_data (ram_q)
  );

  // Zeroing qualifier travels alongside the RAM read register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ok      <= 1'b0;
      coef_valid <= 1'b0;
    end else begin
      rd_ok      <= (coefaddress < ADDR_W'(NTAPS)) && bank_valid[active_bank];
      coef_valid <= bank_valid[active_bank];
    end
  end

  assign coefdata = rd_ok ? ram_q : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      bank_valid  <= 2'b00;
      active_bank <= 1'b0;
      wr_ready    <= 1'b0;
      load_full   <= 1'b0;
      swap_done   <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state              <= LOAD;
            ptr                <= '0;
            wr_ready           <= 1'b1;
            bank_valid[shadow] <= 1'b0;
          end
        end
        LOAD: begin
          if (load_start) begin
            ptr <= '0;
          end else if (wr_valid) begin
            if (ptr == ADDR_W'(NTAPS - 1)) begin
              state              <= FULL;
              ptr                <= '0;
              wr_ready           <= 1'b0;
              load_full          <= 1'b1;
              bank_valid[shadow] <= 1'b1;
            end else begin
              ptr <= ptr + ADDR_W'(1);
            end
          end
        end
        FULL: begin
          if (frame_sync) begin
            active_bank <= shadow;
            swap_done   <= 1'b1;
            load_full   <= 1'b0;
            if (load_start) begin
              // old active bank becomes the new shadow and is reloaded
              state                   <= LOAD;
              ptr                     <= '0;
              wr_ready                <= 1'b1;
              bank_valid[active_bank] <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (load_start) begin
            state              <= LOAD;
            ptr                <= '0;
            wr_ready           <= 1'b1;
            load_full          <= 1'b0;
            bank_valid[shadow] <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          wr_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule
